dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
// - Sits directly downstream of dcache and icache; multiplexes both miss/evict request streams onto the single
//   memory port and routes returning load data back to the requester that owns each memory tag.
// - dcache has priority; starvation counter protects icache; per-tag owner table steers Dmem/Imem responses.
// PARAMETERS
// - NUM_MEM_TAGS    16  tag space of memory (tag 0 = invalid/not accepted)
// - STARVE_LIMIT    8   consecutive icache denials before icache is forced priority for one grant
// PORTS
// - clk                 in   1     clock
// - reset               in   1     async, active-high
// - proc2Dmem_command   in   2     dcache request (BUS_NONE/BUS_LOAD/BUS_STORE)
// - proc2Dmem_addr      in   XLEN  dcache address, 8-byte aligned
// - proc2Dmem_data      in   64    dcache store data (evictions)
// - Dmem2proc_response  out  4     tag accepted for dcache this cycle, 0 = not accepted
// - Dmem2proc_data      out  64    returning data for dcache
// - Dmem2proc_tag       out  4     returning tag for dcache, 0 = none
// - proc2Imem_command   in   2     icache request (loads only)
// - proc2Imem_addr      in   XLEN  icache address
// - Imem2proc_response  out  4     tag accepted for icache, 0 = not accepted
// - Imem2proc_data      out  64    returning data for icache
// - Imem2proc_tag       out  4     returning tag for icache, 0 = none
// - proc2mem_command    out  2     to memory
// - proc2mem_addr       out  XLEN  to memory
// - proc2mem_data       out  64    to memory
// - mem2proc_response   in   4     memory accept tag
// - mem2proc_data       in   64    memory return data
// - mem2proc_tag        in   4     memory return tag
// - arb_tag_error       out  1     sticky: return tag with no valid owner, or accept on an already-owned tag
// BEHAVIOUR
// - Grant is combinational, zero latency. grant_d = (D cmd != NONE) && !(starved && I cmd != NONE).
//   grant_i = (I cmd != NONE) && !grant_d. Neither -> proc2mem_command = BUS_NONE, addr/data = 0.
// - Granted side's command/addr/data drive memory; its *_response = mem2proc_response; loser's response = 0.
// - Starvation counter (3..$clog2 bits): +1 when I requests and D granted; cleared when grant_i or I idle.
//   starved = (count >= STARVE_LIMIT); saturates, never wraps.
// - Owner table: NUM_MEM_TAGS entries {valid, owner_is_d}. On posedge, if granted cmd == BUS_LOAD and
//   mem2proc_response != 0: entry[response] <= {1, grant_d}. Stores are not recorded (no data returns).
// - Return routing (combinational from table state): if mem2proc_tag != 0 and entry valid -> owner side gets
//   mem2proc_tag/mem2proc_data; other side tag = 0. Data outputs always carry mem2proc_data; only tags gate.
//   On posedge the returned entry valid <= 0.
// - Same-cycle return and re-accept of the same tag: allocation wins (entry ends valid with new owner).
// - Return tag with invalid entry: no side sees the tag; arb_tag_error <= 1.
// - Accept on tag whose entry is valid and not returning this cycle: overwrite, arb_tag_error <= 1.
// - Tag 0 never allocated or routed.
// - Reset (async, any time): all entries invalid, starvation count 0, arb_tag_error 0. Combinational outputs
//   follow inputs; returns during reset are dropped (table empty).
// - In-flight loads lost by mid-operation reset are not replayed; caches are reset together.
// STRUCTURE
// - Shared package (sys_defs): BUS_COMMAND enum (BUS_NONE/BUS_LOAD/BUS_STORE), XLEN, NUM_MEM_TAGS,
//   typedef MEM_TAG (4 bits), typedef TAG_OWNER_ENTRY {valid, owner_is_d}.
// - One sub-module: mem_tag_owner_table (alloc port, release port, lookup port, error flag).
// - Top holds grant logic, starvation counter, muxes.
// TESTING
// - D LOAD 0x1000, I LOAD 0x2000 same cycle, resp=3 -> mem gets D addr 0x1000, Dmem2proc_response=3,
//   Imem2proc_response=0; later mem2proc_tag=3 -> Dmem2proc_tag=3, Imem2proc_tag=0.
// - I LOAD 0x40 alone, resp=5; 10 cycles later tag=5, data=64'hDEADBEEF_CAFEF00D -> Imem2proc_tag=5 with
//   that data, Dmem2proc_tag=0; entry 5 invalid afterwards.
// - D STORE 0xF700 every cycle, I LOAD pending -> after 8 denials I granted on 9th cycle;
//   D response 0 that cycle; counter clears.
// - D STORE accepted tag 7, then mem2proc_tag=7 -> no side sees tag, arb_tag_error=1 (stores not owned).
// - Tag 4 returns to D while I accepted tag 4 same cycle -> D sees tag 4 now; next return of 4 goes to I;
//   arb_tag_error stays 0.
// - Assert reset with tags 2,6 outstanding, deassert, return tag 2 -> dropped, arb_tag_error=1;
//   starvation count 0.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared memory-bus definitions for the dcache/icache to memory arbiter.
// Bus command encoding, tag type and owner-table entry layout.
package dmem_arbiter_pkg;

    localparam int XLEN         = 32;
    localparam int NUM_MEM_TAGS = 16;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;

    typedef logic [3:0] MEM_TAG;

    typedef struct packed {
        logic valid;
        logic owner_is_d;
    } TAG_OWNER_ENTRY;

    function automatic logic bus_active(input BUS_COMMAND cmd);
        return cmd != BUS_NONE;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the dcache, icache and memory bus signals seen by the arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface dmem_arbiter_if
    import dmem_arbiter_pkg::*;
    ();

    BUS_COMMAND        proc2Dmem_command;
    logic [XLEN-1:0]   proc2Dmem_addr;
    logic [63:0]       proc2Dmem_data;
    MEM_TAG            Dmem2proc_response;
    logic [63:0]       Dmem2proc_data;
    MEM_TAG            Dmem2proc_tag;

    BUS_COMMAND        proc2Imem_command;
    logic [XLEN-1:0]   proc2Imem_addr;
    MEM_TAG            Imem2proc_response;
    logic [63:0]       Imem2proc_data;
    MEM_TAG            Imem2proc_tag;

    BUS_COMMAND        proc2mem_command;
    logic [XLEN-1:0]   proc2mem_addr;
    logic [63:0]       proc2mem_data;
    MEM_TAG            mem2proc_response;
    logic [63:0]       mem2proc_data;
    MEM_TAG            mem2proc_tag;

    modport slave (
        input  proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data,
        output Dmem2proc_response, Dmem2proc_data, Dmem2proc_tag,
        input  proc2Imem_command, proc2Imem_addr,
        output Imem2proc_response, Imem2proc_data, Imem2proc_tag,
        output proc2mem_command, proc2mem_addr, proc2mem_data,
        input  mem2proc_response, mem2proc_data, mem2proc_tag
    );

    modport master (
        output proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data,
        input  Dmem2proc_response, Dmem2proc_data, Dmem2proc_tag,
        output proc2Imem_command, proc2Imem_addr,
        input  Imem2proc_response, Imem2proc_data, Imem2proc_tag,
        input  proc2mem_command, proc2mem_addr, proc2mem_data,
        output mem2proc_response, mem2proc_data, mem2proc_tag
    );

endinterface

// File: rtl/dmem_arbiter_owner_table.sv
// Per-tag owner table: records which cache issued each outstanding load and
// flags returns with no owner or accepts that clobber a live entry (sticky).
module mem_tag_owner_table
    import dmem_arbiter_pkg::*;
#(
    parameter int NUM_TAGS = NUM_MEM_TAGS
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   alloc_en_i,
    input  MEM_TAG alloc_tag_i,
    input  logic   alloc_is_d_i,
    input  MEM_TAG ret_tag_i,
    output logic   ret_valid_o,
    output logic   ret_is_d_o,
    output logic   err_o
);

    TAG_OWNER_ENTRY table_q [NUM_TAGS];
    TAG_OWNER_ENTRY table_d [NUM_TAGS];
    TAG_OWNER_ENTRY ret_entry;
    logic           err_q, err_d;
    logic           ret_hit, alloc_ok, same_tag_turnover;

    always_comb begin
        ret_entry         = table_q[ret_tag_i];
        ret_hit           = (ret_tag_i != '0) && ret_entry.valid;
        alloc_ok          = alloc_en_i && (alloc_tag_i != '0);
        same_tag_turnover = ret_hit && (ret_tag_i == alloc_tag_i);

        ret_valid_o = ret_hit;
        ret_is_d_o  = ret_entry.owner_is_d;

        table_d = table_q;
        if (ret_hit)
            table_d[ret_tag_i].valid = 1'b0;
        // Allocation is applied after release so a same-cycle re-accept wins.
        if (alloc_ok)
            table_d[alloc_tag_i] = '{valid: 1'b1, owner_is_d: alloc_is_d_i};

        err_d = err_q;
        if ((ret_tag_i != '0) && !ret_entry.valid)
            err_d = 1'b1;
        if (alloc_ok && table_q[alloc_tag_i].valid && !same_tag_turnover)
            err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_TAGS; k++)
                table_q[k] <= '0;
            err_q <= 1'b0;
        end else begin
            table_q <= table_d;
            err_q   <= err_d;
        end
    end

    assign err_o = err_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-into-one memory port arbiter: dcache priority with an icache starvation
// guard, and tag-based steering of returning load data to its requester.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus,
    output logic           arb_tag_error
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_q, starve_d;
    logic             d_req, i_req, starved;
    logic             grant_d, grant_i;
    BUS_COMMAND       granted_cmd;
    logic             alloc_en;
    logic             ret_valid, ret_is_d;

    always_comb begin
        d_req   = bus_active(bus.proc2Dmem_command);
        i_req   = bus_active(bus.proc2Imem_command);
        starved = (starve_q >= CNT_W'(STARVE_LIMIT));
        grant_d = d_req && !(starved && i_req);
        grant_i = i_req && !grant_d;
    end

    always_comb begin
        granted_cmd            = BUS_NONE;
        bus.proc2mem_command   = BUS_NONE;
        bus.proc2mem_addr      = '0;
        bus.proc2mem_data      = '0;
        bus.Dmem2proc_response = '0;
        bus.Imem2proc_response = '0;
        if (grant_d) begin
            granted_cmd            = bus.proc2Dmem_command;
            bus.proc2mem_command   = bus.proc2Dmem_command;
            bus.proc2mem_addr      = bus.proc2Dmem_addr;
            bus.proc2mem_data      = bus.proc2Dmem_data;
            bus.Dmem2proc_response = bus.mem2proc_response;
        end else if (grant_i) begin
            granted_cmd            = bus.proc2Imem_command;
            bus.proc2mem_command   = bus.proc2Imem_command;
            bus.proc2mem_addr      = bus.proc2Imem_addr;
            bus.Imem2proc_response = bus.mem2proc_response;
        end
    end

    // Counts consecutive icache denials; saturates at the limit instead of wrapping.
    always_comb begin
        starve_d = starve_q;
        if (!i_req || grant_i)
            starve_d = '0;
        else if (grant_d && (starve_q < CNT_W'(STARVE_LIMIT)))
            starve_d = starve_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            starve_q <= '0;
        else
            starve_q <= starve_d;
    end

    // Only loads produce a return, so only they claim a tag owner.
    assign alloc_en = (granted_cmd == BUS_LOAD) && (bus.mem2proc_response != '0);

    mem_tag_owner_table #(
        .NUM_TAGS (NUM_MEM_TAGS)
    ) u_owner_table (
        .clk          (clk),
        .reset        (reset),
        .alloc_en_i   (alloc_en),
        .alloc_tag_i  (bus.mem2proc_response),
        .alloc_is_d_i (grant_d),
        .ret_tag_i    (bus.mem2proc_tag),
        .ret_valid_o  (ret_valid),
        .ret_is_d_o   (ret_is_d),
        .err_o        (arb_tag_error)
    );

    always_comb begin
        bus.Dmem2proc_data = bus.mem2proc_data;
        bus.Imem2proc_data = bus.mem2proc_data;
        bus.Dmem2proc_tag  = (ret_valid &&  ret_is_d) ? bus.mem2proc_tag : '0;
        bus.Imem2proc_tag  = (ret_valid && !ret_is_d) ? bus.mem2proc_tag : '0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed scoreboard bench for dmem_arbiter: expectations are queued as
// stimulus is applied and compared against the settled DUT outputs.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int S_MCMD  = 0;
    localparam int S_MADDR = 1;
    localparam int S_MDATA = 2;
    localparam int S_DRESP = 3;
    localparam int S_IRESP = 4;
    localparam int S_DTAG  = 5;
    localparam int S_ITAG  = 6;
    localparam int S_DDATA = 7;
    localparam int S_IDATA = 8;
    localparam int S_ERR   = 9;

    logic clk = 1'b0;
    logic reset;
    logic arb_tag_error;

    dmem_arbiter_if bus ();

    dmem_arbiter #(
        .STARVE_LIMIT (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .arb_tag_error (arb_tag_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          sel;
        logic [63:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] observe(input int sel);
        case (sel)
            S_MCMD:  return 64'(bus.proc2mem_command);
            S_MADDR: return 64'(bus.proc2mem_addr);
            S_MDATA: return bus.proc2mem_data;
            S_DRESP: return 64'(bus.Dmem2proc_response);
            S_IRESP: return 64'(bus.Imem2proc_response);
            S_DTAG:  return 64'(bus.Dmem2proc_tag);
            S_ITAG:  return 64'(bus.Imem2proc_tag);
            S_DDATA: return bus.Dmem2proc_data;
            S_IDATA: return bus.Imem2proc_data;
            default: return 64'(arb_tag_error);
        endcase
    endfunction

    task automatic expect_sig(input string tag, input int sel, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val(e.tag, observe(e.sel), e.val);
        end
    endtask

    task automatic set_in(input BUS_COMMAND dc, input logic [31:0] da, input logic [63:0] dd,
                          input BUS_COMMAND ic, input logic [31:0] ia,
                          input MEM_TAG resp, input MEM_TAG rtag, input logic [63:0] rdata);
        bus.proc2Dmem_command = dc;
        bus.proc2Dmem_addr    = da;
        bus.proc2Dmem_data    = dd;
        bus.proc2Imem_command = ic;
        bus.proc2Imem_addr    = ia;
        bus.mem2proc_response = resp;
        bus.mem2proc_tag      = rtag;
        bus.mem2proc_data     = rdata;
    endtask

    task automatic idle();
        set_in(BUS_NONE, 32'h0, 64'h0, BUS_NONE, 32'h0, 4'd0, 4'd0, 64'h0);
    endtask

    // Let combinational outputs settle, compare, then advance one clock.
    task automatic cycle();
        #1;
        drain();
        @(posedge clk);
        #1;
    endtask

    task automatic starve_run(input string pfx, input MEM_TAG iresp);
        for (int k = 0; k < 8; k++) begin
            set_in(BUS_STORE, 32'hF700, 64'h55, BUS_LOAD, 32'h3000, 4'd0, 4'd0, 64'h0);
            expect_sig({pfx, "_deny_cmd"},  S_MCMD,  64'(BUS_STORE));
            expect_sig({pfx, "_deny_addr"}, S_MADDR, 64'hF700);
            expect_sig({pfx, "_deny_iresp"}, S_IRESP, 64'd0);
            cycle();
        end
        set_in(BUS_STORE, 32'hF700, 64'h55, BUS_LOAD, 32'h3000, iresp, 4'd0, 64'h0);
        expect_sig({pfx, "_force_cmd"},   S_MCMD,  64'(BUS_LOAD));
        expect_sig({pfx, "_force_addr"},  S_MADDR, 64'h3000);
        expect_sig({pfx, "_force_dresp"}, S_DRESP, 64'd0);
        expect_sig({pfx, "_force_iresp"}, S_IRESP, 64'(iresp));
        cycle();
        set_in(BUS_STORE, 32'hF700, 64'h55, BUS_LOAD, 32'h3000, 4'd0, 4'd0, 64'h0);
        expect_sig({pfx, "_cleared_addr"}, S_MADDR, 64'hF700);
        cycle();
        idle();
    endtask

    initial begin
        #100000;
        n_fail++;
        $display("FAIL timeout: simulation did not complete");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        reset = 1'b1;
        set_in(BUS_LOAD, 32'h10, 64'h0, BUS_NONE, 32'h0, 4'd0, 4'd3, 64'h0);
        expect_sig("rst_err",    S_ERR,   64'd0);
        expect_sig("rst_follow", S_MADDR, 64'h10);
        expect_sig("rst_dtag",   S_DTAG,  64'd0);
        expect_sig("rst_itag",   S_ITAG,  64'd0);
        cycle();
        idle();
        reset = 1'b0;
        cycle();

        // dcache wins a same-cycle collision; return goes to dcache
        set_in(BUS_LOAD, 32'h1000, 64'h0, BUS_LOAD, 32'h2000, 4'd3, 4'd0, 64'h0);
        expect_sig("t1_addr",  S_MADDR, 64'h1000);
        expect_sig("t1_cmd",   S_MCMD,  64'(BUS_LOAD));
        expect_sig("t1_dresp", S_DRESP, 64'd3);
        expect_sig("t1_iresp", S_IRESP, 64'd0);
        cycle();
        idle();
        cycle();
        set_in(BUS_NONE, 32'h0, 64'h0, BUS_NONE, 32'h0, 4'd0, 4'd3, 64'h1111_2222_3333_4444);
        expect_sig("t1_dtag",  S_DTAG,  64'd3);
        expect_sig("t1_itag",  S_ITAG,  64'd0);
        expect_sig("t1_ddata", S_DDATA, 64'h1111_2222_3333_4444);
        expect_sig("t1_idata", S_IDATA, 64'h1111_2222_3333_4444);
        cycle();
        idle();

        // icache load alone, return ten cycles later
        set_in(BUS_NONE, 32'h0, 64'h0, BUS_LOAD, 32'h40, 4'd5, 4'd0, 64'h0);
        expect_sig("t2_addr",  S_MADDR, 64'h40);
        expect_sig("t2_iresp", S_IRESP, 64'd5);
        expect_sig("t2_dresp", S_DRESP, 64'd0);
        cycle();
        idle();
        for (int k = 0; k < 10; k++) cycle();
        set_in(BUS_NONE, 32'h0, 64'h0, BUS_NONE, 32'h0, 4'd0, 4'd5, 64'hDEADBEEF_CAFEF00D);
        expect_sig("t2_itag",  S_ITAG,  64'd5);
        expect_sig("t2_idata", S_IDATA, 64'hDEADBEEF_CAFEF00D);
        expect_sig("t2_dtag",  S_DTAG,  64'd0);
        cycle();
        idle();

        starve_run("t3", 4'd9);

        // Tag 4 returns to dcache while icache re-acquires it in the same cycle
        set_in(BUS_LOAD, 32'h100, 64'h0, BUS_NONE, 32'h0, 4'd4, 4'd0, 64'h0);
        expect_sig("t4_dresp", S_DRESP, 64'd4);
        cycle();
        set_in(BUS_NONE, 32'h0, 64'h0, BUS_LOAD, 32'h200, 4'd4, 4'd4, 64'hA5);
        expect_sig("t4_dtag_now", S_DTAG,  64'd4);
        expect_sig("t4_itag_now", S_ITAG,  64'd0);
        expect_sig("t4_iresp",    S_IRESP, 64'd4);
        cycle();
        set_in(BUS_NONE, 32'h0, 64'h0, BUS_NONE, 32'h0, 4'd0, 4'd4, 64'hB6);
        expect_sig("t4_itag_next", S_ITAG, 64'd4);
        expect_sig("t4_dtag_next", S_DTAG, 64'd0);
        cycle();
        idle();
        expect_sig("t4_err", S_ERR, 64'd0);
        drain();

        // Tag 5 was already returned; a second return has no owner
        set_in(BUS_NONE, 32'h0, 64'h0, BUS_NONE, 32'h0, 4'd0, 4'd5, 64'h0);
        expect_sig("t5_dtag", S_DTAG, 64'd0);
        expect_sig("t5_itag", S_ITAG, 64'd0);
        cycle();
        idle();
        expect_sig("t5_err", S_ERR, 64'd1);
        drain();

        reset = 1'b1;
        cycle();
        reset = 1'b0;
        expect_sig("t6_err_clr", S_ERR, 64'd0);
        drain();

        // Stores never own a tag
        set_in(BUS_STORE, 32'h500, 64'h77, BUS_NONE, 32'h0, 4'd7, 4'd0, 64'h0);
        expect_sig("t6_dresp", S_DRESP, 64'd7);
        expect_sig("t6_mdata", S_MDATA, 64'h77);
        cycle();
        set_in(BUS_NONE, 32'h0, 64'h0, BUS_NONE, 32'h0, 4'd0, 4'd7, 64'h0);
        expect_sig("t6_dtag", S_DTAG, 64'd0);
        expect_sig("t6_itag", S_ITAG, 64'd0);
        cycle();
        idle();
        expect_sig("t6_err", S_ERR, 64'd1);
        drain();

        // Mid-operation reset with tags 2 and 6 outstanding and a partial starve count
        set_in(BUS_LOAD, 32'h800, 64'h0, BUS_NONE, 32'h0, 4'd2, 4'd0, 64'h0);
        cycle();
        set_in(BUS_NONE, 32'h0, 64'h0, BUS_LOAD, 32'h900, 4'd6, 4'd0, 64'h0);
        cycle();
        for (int k = 0; k < 5; k++) begin
            set_in(BUS_STORE, 32'hF700, 64'h0, BUS_LOAD, 32'h3000, 4'd0, 4'd0, 64'h0);
            cycle();
        end
        #2;
        reset = 1'b1;
        set_in(BUS_NONE, 32'h0, 64'h0, BUS_NONE, 32'h0, 4'd0, 4'd6, 64'h0);
        expect_sig("t7_async_err", S_ERR,  64'd0);
        expect_sig("t7_rst_itag",  S_ITAG, 64'd0);
        #1;
        drain();
        @(posedge clk);
        #1;
        reset = 1'b0;
        set_in(BUS_NONE, 32'h0, 64'h0, BUS_NONE, 32'h0, 4'd0, 4'd2, 64'h0);
        expect_sig("t7_dtag", S_DTAG, 64'd0);
        expect_sig("t7_itag", S_ITAG, 64'd0);
        cycle();
        idle();
        expect_sig("t7_err", S_ERR, 64'd1);
        drain();
        starve_run("t7", 4'd9);
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
